// File: rtl/timer_ctrl.sv
// Register-mapped sequencer for one prescaled up/down timer counter.
// Shadowed configuration, RUN/PAUSE/DONE control, and a sticky maskable interrupt.
module timer_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter logic [31:0] RST_LOAD = 32'h0000_0000,
  parameter logic [15:0] RST_PSC  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              tim_en,
  output logic              tim_reset,
  output logic [15:0]       tim_prescaler,
  output logic [31:0]       tim_load,
  output logic              tim_up_down,
  output logic              tim_one_shot,
  input  logic              tim_tick,
  input  logic [31:0]       tim_count,
  output logic              irq,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PSC    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LOAD   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(5);

  state_e      state_q, state_d;
  logic        sh_up_q, sh_up_d;
  logic        sh_os_q, sh_os_d;
  logic [15:0] sh_psc_q, sh_psc_d;
  logic [31:0] sh_load_q, sh_load_d;
  logic        irq_en_q, irq_en_d;
  logic        act_up_q, act_up_d;
  logic        act_os_q, act_os_d;
  logic [15:0] act_psc_q, act_psc_d;
  logic [31:0] act_load_q, act_load_d;
  logic        tick_q, tick_d;
  logic        tick_flag_q, tick_flag_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_cfg, wr_psc, wr_load, wr_stat, wr_cmd;
  logic ev, clr_tick, copy_act;

  assign wr_cfg  = wr_en && (addr == A_CFG);
  assign wr_psc  = wr_en && (addr == A_PSC);
  assign wr_load = wr_en && (addr == A_LOAD);
  assign wr_stat = wr_en && (addr == A_STATUS);
  assign wr_cmd  = wr_en && (addr == A_CMD);

  // Rising edge of the counter's expiry level, seen only while running.
  assign ev       = (state_q == S_RUN) && tim_tick && !tick_q;
  assign clr_tick = wr_stat && wdata[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (ev && act_os_q) state_d = S_DONE;
      default: ;
    endcase
    if (wr_cmd) begin
      if (wdata[1])                               state_d = S_IDLE;
      else if (wdata[0])                          state_d = S_ARM;
      else if (wdata[2] && (state_q == S_RUN))    state_d = S_PAUSED;
      else if (wdata[3] && (state_q == S_PAUSED)) state_d = S_RUN;
    end
  end

  always_comb begin
    sh_up_d   = wr_cfg  ? wdata[0]     : sh_up_q;
    sh_os_d   = wr_cfg  ? wdata[1]     : sh_os_q;
    irq_en_d  = wr_cfg  ? wdata[2]     : irq_en_q;
    sh_psc_d  = wr_psc  ? wdata[15:0]  : sh_psc_q;
    sh_load_d = wr_load ? wdata        : sh_load_q;

    // Copy the pre-write shadow so a same-cycle register write lands next period.
    copy_act   = (state_d == S_ARM) || (ev && !act_os_q);
    act_up_d   = copy_act ? sh_up_q   : act_up_q;
    act_os_d   = copy_act ? sh_os_q   : act_os_q;
    act_psc_d  = copy_act ? sh_psc_q  : act_psc_q;
    act_load_d = copy_act ? sh_load_q : act_load_q;

    tick_d = ((state_q == S_ARM) || (state_d == S_ARM)) ? 1'b0 : tim_tick;

    tick_flag_d = tick_flag_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    if (clr_tick)              tick_flag_d = 1'b0;
    if (wr_stat && wdata[1])   done_d      = 1'b0;
    if (wr_stat && wdata[2])   overrun_d   = 1'b0;
    if (ev)                    tick_flag_d = 1'b1;
    if (ev && tick_flag_q && !clr_tick) overrun_d = 1'b1;
    if (ev && act_os_q && (state_d == S_DONE)) done_d = 1'b1;

    irq_d = irq_en_q && (tick_flag_q || done_q);

    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (addr)
        A_CFG:    rdata_d = {29'd0, irq_en_q, sh_os_q, sh_up_q};
        A_PSC:    rdata_d = {16'd0, sh_psc_q};
        A_LOAD:   rdata_d = sh_load_q;
        A_STATUS: rdata_d = {26'd0, state_q, overrun_q, done_q, tick_flag_q};
        A_COUNT:  rdata_d = tim_count;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_up_q     <= 1'b0;
      sh_os_q     <= 1'b0;
      sh_psc_q    <= RST_PSC;
      sh_load_q   <= RST_LOAD;
      irq_en_q    <= 1'b0;
      act_up_q    <= 1'b0;
      act_os_q    <= 1'b0;
      act_psc_q   <= RST_PSC;
      act_load_q  <= RST_LOAD;
      tick_q      <= 1'b0;
      tick_flag_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sh_up_q     <= sh_up_d;
      sh_os_q     <= sh_os_d;
      sh_psc_q    <= sh_psc_d;
      sh_load_q   <= sh_load_d;
      irq_en_q    <= irq_en_d;
      act_up_q    <= act_up_d;
      act_os_q    <= act_os_d;
      act_psc_q   <= act_psc_d;
      act_load_q  <= act_load_d;
      tick_q      <= tick_d;
      tick_flag_q <= tick_flag_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign tim_en        = (state_q == S_ARM) || (state_q == S_RUN);
  assign tim_reset     = (state_q == S_ARM);
  assign busy          = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_PAUSED);
  assign tim_prescaler = act_psc_q;
  assign tim_load      = act_load_q;
  assign tim_up_down   = act_up_q;
  assign tim_one_shot  = act_os_q;
  assign irq           = irq_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural prescaled up/down counter attached.
module tb_timer_ctrl;
  localparam logic [31:0] RST_LOAD = 32'h0000_0009;
  localparam logic [15:0] RST_PSC  = 16'h0002;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic        tim_en, tim_reset, tim_up_down, tim_one_shot, tim_tick, irq, busy;
  logic [15:0] tim_prescaler;
  logic [31:0] tim_load, tim_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_ctrl #(.ADDR_W(3), .RST_LOAD(RST_LOAD), .RST_PSC(RST_PSC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tim_en(tim_en), .tim_reset(tim_reset), .tim_prescaler(tim_prescaler),
    .tim_load(tim_load), .tim_up_down(tim_up_down), .tim_one_shot(tim_one_shot),
    .tim_tick(tim_tick), .tim_count(tim_count), .irq(irq), .busy(busy)
  );

  // Counter: clear loads 0 (up) or LOAD (down); expiry level at the terminal value.
  logic [31:0] cnt  = '0;
  logic [15:0] pcnt = '0;
  always @(posedge clk) begin
    if (tim_reset) begin
      cnt  <= tim_up_down ? 32'd0 : tim_load;
      pcnt <= '0;
    end else if (tim_en) begin
      if (pcnt == tim_prescaler) begin
        pcnt <= '0;
        if (tim_up_down) begin
          if (cnt == tim_load) begin if (!tim_one_shot) cnt <= '0; end
          else cnt <= cnt + 32'd1;
        end else begin
          if (cnt == 32'd0) begin if (!tim_one_shot) cnt <= tim_load; end
          else cnt <= cnt - 32'd1;
        end
      end else pcnt <= pcnt + 16'd1;
    end
  end
  assign tim_count = cnt;
  assign tim_tick  = tim_up_down ? (cnt == tim_load) : (cnt == 32'd0);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step();
    wr_en = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic wait_cnt(input logic [31:0] v, output bit ok);
    int n = 0;
    while (tim_count !== v && n < 200) begin step(); n++; end
    ok = (tim_count === v);
  endtask

  task automatic wait_irq(input logic v, output bit ok);
    int n = 0;
    while (irq !== v && n < 200) begin step(); n++; end
    ok = (irq === v);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) step();
    total++; if (tim_en !== 1'b0)          begin bad++; $display("FAIL reset_en: got %b want 0", tim_en); end
    total++; if (tim_reset !== 1'b0)       begin bad++; $display("FAIL reset_treset: got %b want 0", tim_reset); end
    total++; if (busy !== 1'b0)            begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (irq !== 1'b0)             begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (tim_load !== RST_LOAD)    begin bad++; $display("FAIL reset_load: got %h want %h", tim_load, RST_LOAD); end
    total++; if (tim_prescaler !== RST_PSC) begin bad++; $display("FAIL reset_psc: got %h want %h", tim_prescaler, RST_PSC); end
    total++; if ({tim_up_down, tim_one_shot} !== 2'b00) begin bad++; $display("FAIL reset_mode: got %b%b want 00", tim_up_down, tim_one_shot); end
    total++; if (rdata !== 32'd0)          begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst = 1'b0;
    step();
    rd(3'd1, d);
    total++; if (d !== {16'd0, RST_PSC})   begin bad++; $display("FAIL reset_psc_read: got %h want %h", d, RST_PSC); end
  endtask

  task automatic test_periodic_up();
    logic [31:0] d, pre;
    int n, t1;
    bit ok1, ok2;
    wr(3'd1, 32'd0); wr(3'd2, 32'd3); wr(3'd0, 32'd5);
    wr(3'd5, 32'd1);
    total++; if ({tim_reset, tim_en, busy} !== 3'b111) begin bad++; $display("FAIL p_arm: reset/en/busy=%b want 111", {tim_reset, tim_en, busy}); end
    total++; if (tim_load !== 32'd3)       begin bad++; $display("FAIL p_load: got %0d want 3", tim_load); end
    step();
    total++; if (tim_reset !== 1'b0 || tim_count !== 32'd0) begin bad++; $display("FAIL p_run: reset=%b count=%0d want 0/0", tim_reset, tim_count); end
    n = 1;
    while (irq !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (n != 6 || irq !== 1'b1)   begin bad++; $display("FAIL p_irq_latency: %0d cycles after START want 6", n); end
    t1 = cyc;
    wr(3'd3, 32'd1);
    wait_irq(1'b0, ok1);
    wait_irq(1'b1, ok2);
    total++; if (!ok1 || !ok2 || (cyc - t1) != 4) begin bad++; $display("FAIL p_period: irq edge spacing %0d want 4", cyc - t1); end
    rd(3'd3, d);
    total++; if (d !== 32'h11)             begin bad++; $display("FAIL p_status: got %h want 00000011", d); end
    rd(3'd0, d);
    total++; if (d !== 32'h5)              begin bad++; $display("FAIL p_cfg_read: got %h want 5", d); end
    pre = tim_count;
    rd(3'd4, d);
    total++; if (d !== pre)                begin bad++; $display("FAIL p_count_read: got %0d want %0d", d, pre); end
    wr(3'd5, 32'd2);
  endtask

  task automatic test_oneshot_down();
    logic [31:0] d, exp;
    int e;
    wr(3'd1, 32'd1); wr(3'd2, 32'd5); wr(3'd0, 32'd6); wr(3'd3, 32'd7);
    wr(3'd5, 32'd1);
    total++; if ({tim_load, tim_prescaler, tim_up_down, tim_one_shot, tim_reset} !== {32'd5, 16'd1, 3'b011})
      begin bad++; $display("FAIL o_arm: load=%0d psc=%0d ud=%b os=%b rst=%b want 5/1/0/1/1", tim_load, tim_prescaler, tim_up_down, tim_one_shot, tim_reset); end
    for (int k = 0; k < 12; k++) begin
      step();
      exp = 32'(5 - k / 2);
      total++; if (tim_count !== exp) begin bad++; $display("FAIL o_count[%0d]: got %0d want %0d", k, tim_count, exp); end
    end
    total++; if (tim_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL o_done_en: en=%b busy=%b want 0/0", tim_en, busy); end
    e = 0;
    repeat (20) begin step(); if (tim_count !== 32'd0) e++; end
    total++; if (e != 0)                   begin bad++; $display("FAIL o_hold: %0d cycles off terminal, final %0d want 0", e, tim_count); end
    total++; if (irq !== 1'b1)             begin bad++; $display("FAIL o_irq: got %b want 1", irq); end
    rd(3'd3, d);
    total++; if (d !== 32'h23)             begin bad++; $display("FAIL o_status: got %h want 00000023", d); end
  endtask

  task automatic test_shadow();
    logic [31:0] d;
    int t1;
    bit ok;
    wr(3'd5, 32'd2); wr(3'd3, 32'd7);
    wr(3'd0, 32'd1); wr(3'd1, 32'd0); wr(3'd2, 32'd10);
    wr(3'd5, 32'd1);
    repeat (3) step();
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd2; wdata = 32'd4;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    total++; if (rdata !== 32'd10)         begin bad++; $display("FAIL s_rd_wr_same: got %0d want 10", rdata); end
    total++; if (tim_load !== 32'd10)      begin bad++; $display("FAIL s_active_hold: got %0d want 10", tim_load); end
    wait_cnt(32'd10, ok);
    total++; if (!ok || tim_load !== 32'd10) begin bad++; $display("FAIL s_at_expiry: load=%0d count=%0d want 10/10", tim_load, tim_count); end
    t1 = cyc;
    step();
    total++; if (tim_load !== 32'd4 || tim_count !== 32'd0) begin bad++; $display("FAIL s_swap: load=%0d count=%0d want 4/0", tim_load, tim_count); end
    wait_cnt(32'd4, ok);
    total++; if (!ok || (cyc - t1) != 5)   begin bad++; $display("FAIL s_period: %0d cycles want 5", cyc - t1); end
    rd(3'd2, d);
    total++; if (d !== 32'd4)              begin bad++; $display("FAIL s_load_read: got %0d want 4", d); end
  endtask

  task automatic test_pause_resume();
    logic [31:0] d;
    int e;
    bit ok;
    wr(3'd5, 32'd2); wr(3'd2, 32'd20); wr(3'd5, 32'd1);
    wait_cnt(32'd6, ok);
    wr(3'd5, 32'd4);
    total++; if (!ok || tim_count !== 32'd7 || busy !== 1'b1 || tim_en !== 1'b0)
      begin bad++; $display("FAIL r_pause: count=%0d busy=%b en=%b want 7/1/0", tim_count, busy, tim_en); end
    e = 0;
    repeat (10) begin step(); if (tim_count !== 32'd7 || busy !== 1'b1) e++; end
    total++; if (e != 0)                   begin bad++; $display("FAIL r_hold: %0d bad cycles, count=%0d want 7", e, tim_count); end
    rd(3'd3, d);
    total++; if (d[5:3] !== 3'd3)          begin bad++; $display("FAIL r_state: got %0d want 3", d[5:3]); end
    rd(3'd4, d);
    total++; if (d !== 32'd7)              begin bad++; $display("FAIL r_count_read: got %0d want 7", d); end
    wr(3'd5, 32'd8);
    total++; if (tim_reset !== 1'b0 || tim_en !== 1'b1 || tim_count !== 32'd7)
      begin bad++; $display("FAIL r_resume: reset=%b en=%b count=%0d want 0/1/7", tim_reset, tim_en, tim_count); end
    step();
    total++; if (tim_count !== 32'd8 || tim_reset !== 1'b0) begin bad++; $display("FAIL r_continue: count=%0d reset=%b want 8/0", tim_count, tim_reset); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    bit ok1, ok2;
    wr(3'd5, 32'd2); wr(3'd3, 32'd7);
    wr(3'd2, 32'd3); wr(3'd0, 32'd1); wr(3'd1, 32'd0);
    wr(3'd5, 32'd1);
    repeat (12) step();
    rd(3'd3, d);
    total++; if (d !== 32'h15)             begin bad++; $display("FAIL v_overrun: status %h want 00000015", d); end
    wr(3'd3, 32'd7);
    wait_cnt(32'd2, ok1);
    wait_cnt(32'd3, ok2);
    wr(3'd3, 32'd1);
    rd(3'd3, d);
    total++; if (!ok1 || !ok2 || d !== 32'h11) begin bad++; $display("FAIL v_w1c_race: status %h want 00000011", d); end
  endtask

  task automatic test_priority_reset();
    logic [31:0] d;
    wr(3'd0, 32'd5);
    wr(3'd5, 32'd3);
    total++; if (busy !== 1'b0 || tim_en !== 1'b0) begin bad++; $display("FAIL c_stop_wins: busy=%b en=%b want 0/0", busy, tim_en); end
    rd(3'd3, d);
    total++; if (d[5:3] !== 3'd0)          begin bad++; $display("FAIL c_state: got %0d want 0", d[5:3]); end
    wr(3'd5, 32'd1);
    repeat (3) step();
    total++; if (busy !== 1'b1 || irq !== 1'b1) begin bad++; $display("FAIL c_prerst: busy=%b irq=%b want 1/1", busy, irq); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({busy, irq, tim_en, tim_reset} !== 4'b0000) begin bad++; $display("FAIL c_rst_flags: busy/irq/en/reset=%b want 0000", {busy, irq, tim_en, tim_reset}); end
    total++; if (tim_load !== RST_LOAD || tim_prescaler !== RST_PSC) begin bad++; $display("FAIL c_rst_act: load=%h psc=%h want %h/%h", tim_load, tim_prescaler, RST_LOAD, RST_PSC); end
    rd(3'd2, d);
    total++; if (d !== RST_LOAD)           begin bad++; $display("FAIL c_rst_shadow: got %h want %h", d, RST_LOAD); end
    rd(3'd3, d);
    total++; if (d !== 32'd0)              begin bad++; $display("FAIL c_rst_status: got %h want 0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd6, d);
    total++; if (d !== 32'd0)              begin bad++; $display("FAIL u_read6: got %h want 0", d); end
    rd(3'd5, d);
    total++; if (d !== 32'd0)              begin bad++; $display("FAIL u_cmd_read: got %h want 0", d); end
    rd(3'd0, d);
    total++; if (d !== 32'd0 || busy !== 1'b0) begin bad++; $display("FAIL u_write7: cfg=%h busy=%b want 0/0", d, busy); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    test_reset();
    test_periodic_up();
    test_oneshot_down();
    test_shadow();
    test_pause_resume();
    test_overrun();
    test_priority_reset();
    test_unmapped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
